// File: rtl/reset_release_sequencer_pkg.sv
// Shared definitions for the reset release sequencer.
//   seq_state_t      : sequencer FSM states (HOLD / WAIT / DONE)
//   DEF_*            : default parameter values
//   idx_width()      : width of the domain index register (minimum 1)
package reset_release_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_N_DOMAINS   = 4;
  localparam int unsigned DEF_SYNC_STAGES = 3;
  localparam int unsigned DEF_DELAY_W     = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Control/status bundle of the reset release sequencer.
//   req_async      : asynchronous reset request, active-high
//   cfg_delay      : gap in cycles between domain releases
//   test_mode      : 1 = domain resets driven from test_reset_n
//   test_reset_n   : reset value for all domains in test mode
//   domain_reset_n : per-domain active-low resets
//   seq_busy       : sequence not complete
//   seq_done       : all domains released
// master = requesting/observing side, slave = the sequencer.
interface reset_release_sequencer_if
  import reset_release_sequencer_pkg::*;
#(
  parameter int unsigned N_DOMAINS = DEF_N_DOMAINS,
  parameter int unsigned DELAY_W   = DEF_DELAY_W
);

  logic                 req_async;
  logic [DELAY_W-1:0]   cfg_delay;
  logic                 test_mode;
  logic                 test_reset_n;
  logic [N_DOMAINS-1:0] domain_reset_n;
  logic                 seq_busy;
  logic                 seq_done;

  modport master (
    output req_async, cfg_delay, test_mode, test_reset_n,
    input  domain_reset_n, seq_busy, seq_done
  );

  modport slave (
    input  req_async, cfg_delay, test_mode, test_reset_n,
    output domain_reset_n, seq_busy, seq_done
  );

endinterface

// File: rtl/reset_release_sequencer_sync.sv
// reset_req_synchronizer: STAGES-deep synchronizer for an asynchronous
// active-high request. Reset forces every stage to 1 so the request reads
// as asserted until STAGES clean samples of 0 have been shifted through.
//   clock     : sampling clock
//   reset_n   : asynchronous active-low reset (sets all stages)
//   req_async : asynchronous request input
//   req_sync  : synchronized request (last stage)
module reset_req_synchronizer #(
  parameter int unsigned STAGES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_async,
  output logic req_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], req_async};
    end
  end

  assign req_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases N_DOMAINS active-low resets one at a time, lowest index first,
// with cfg_delay idle cycles between releases. A synchronized request
// (or reset_n) re-asserts all domains. test_mode bypasses the released
// vector with test_reset_n for scan control; the FSM keeps running.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : request/config/test inputs, domain resets and status
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int unsigned N_DOMAINS   = DEF_N_DOMAINS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DELAY_W     = DEF_DELAY_W
) (
  input logic                      clock,
  input logic                      reset_n,
  reset_release_sequencer_if.slave bus
);

  localparam int unsigned          IDX_W    = idx_width(N_DOMAINS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_DOMAINS - 1);

  seq_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [DELAY_W-1:0]   cnt;
  logic [N_DOMAINS-1:0] rel_q;
  logic                 req_s;

  reset_req_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_async (bus.req_async),
    .req_sync  (req_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= HOLD;
      idx   <= '0;
      cnt   <= '0;
      rel_q <= '0;
    end else begin
      case (state)
        HOLD: begin
          rel_q <= '0;
          if (!req_s) begin
            cnt   <= bus.cfg_delay;
            idx   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A request outranks a release due on the same edge.
          if (req_s) begin
            rel_q <= '0;
            state <= HOLD;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Decoded set keeps the write in range for non-power-of-2 N.
            for (int unsigned k = 0; k < N_DOMAINS; k++) begin
              if (idx == IDX_W'(k)) rel_q[k] <= 1'b1;
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
              cnt <= bus.cfg_delay;
            end
          end
        end
        DONE: begin
          if (req_s) begin
            rel_q <= '0;
            state <= HOLD;
          end
        end
        default: begin
          rel_q <= '0;
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.domain_reset_n = bus.test_mode ? {N_DOMAINS{bus.test_reset_n}} : rel_q;
  assign bus.seq_busy       = (state != DONE);
  assign bus.seq_done       = (state == DONE);

endmodule

// File: tb/tb_reset_release_sequencer.sv
module tb_reset_release_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 3;
  localparam int unsigned DW = 8;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_cnt = 0;

  reset_release_sequencer_if #(.N_DOMAINS(N), .DELAY_W(DW)) bus ();

  reset_release_sequencer #(
    .N_DOMAINS   (N),
    .SYNC_STAGES (S),
    .DELAY_W     (DW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model: request history queue gives the synchronized request;
  // while sequencing, the number of released domains is simply the edges
  // elapsed since the sequence started divided by (gap+1), saturated at N.
  bit          hist[$];
  bit          seq_on;
  int unsigned t_seq;
  int unsigned d_cap;

  always @(posedge clock or negedge reset_n) begin
    bit rs;
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < int'(S); i++) hist.push_back(1'b1);
      seq_on   = 1'b0;
      t_seq    = 0;
      d_cap    = 0;
      edge_cnt = 0;
    end else begin
      edge_cnt++;
      rs = hist[0];
      hist.push_back(bus.req_async);
      void'(hist.pop_front());
      if (rs) begin
        seq_on = 1'b0;
      end else if (!seq_on) begin
        seq_on = 1'b1;
        t_seq  = 0;
        d_cap  = int'(bus.cfg_delay);
      end else begin
        t_seq++;
      end
    end
  end

  function automatic int unsigned model_count();
    int unsigned r;
    if (!seq_on) return 0;
    r = t_seq / (d_cap + 1);
    return (r > N) ? N : r;
  endfunction

  function automatic logic [N-1:0] model_dom();
    int unsigned mask;
    if (bus.test_mode) return {N{bus.test_reset_n}};
    mask = (32'd1 << model_count()) - 32'd1;
    return mask[N-1:0];
  endfunction

  function automatic logic model_done();
    return seq_on && (model_count() == N);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("cyc_dom",  32'(bus.domain_reset_n), 32'(model_dom()));
    check("cyc_busy", 32'(bus.seq_busy),       32'(!model_done()));
    check("cyc_done", 32'(bus.seq_done),       32'(model_done()));
  end

  task automatic imm(input string name, input logic [N-1:0] dom, input logic busy, input logic done);
    check({name, "_dom"},  32'(bus.domain_reset_n), 32'(dom));
    check({name, "_busy"}, 32'(bus.seq_busy),       32'(busy));
    check({name, "_done"}, 32'(bus.seq_done),       32'(done));
  endtask

  // Hand-computed expectation just after edge k (counted from reset release).
  task automatic lit(input int unsigned k, input logic [N-1:0] dom, input logic busy, input logic done);
    int unsigned guard = 0;
    while (edge_cnt < k && guard < 500) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (edge_cnt != k) begin
      n_checks++;
      n_fail++;
      $display("FAIL edge_wait: got edge %0d required edge %0d", edge_cnt, k);
    end else begin
      imm($sformatf("edge%0d", k), dom, busy, done);
    end
  endtask

  task automatic do_reset(input logic [DW-1:0] cfg, input logic req);
    @(posedge clock);
    #2;
    reset_n          = 1'b0;
    bus.req_async    = req;
    bus.cfg_delay    = cfg;
    bus.test_mode    = 1'b0;
    bus.test_reset_n = 1'b0;
    #1;
    imm("in_reset", 4'b0000, 1'b1, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req_async    = 1'b1;
    bus.cfg_delay    = '0;
    bus.test_mode    = 1'b0;
    bus.test_reset_n = 1'b0;

    // Power-up sequence, gap 2, then re-request from DONE with gap 5.
    do_reset(8'd2, 1'b0);
    lit(3,  4'b0000, 1'b1, 1'b0);
    lit(6,  4'b0000, 1'b1, 1'b0);
    lit(7,  4'b0001, 1'b1, 1'b0);
    lit(9,  4'b0001, 1'b1, 1'b0);
    lit(10, 4'b0011, 1'b1, 1'b0);
    lit(13, 4'b0111, 1'b1, 1'b0);
    lit(15, 4'b0111, 1'b1, 1'b0);
    lit(16, 4'b1111, 1'b0, 1'b1);
    lit(18, 4'b1111, 1'b0, 1'b1);
    bus.req_async = 1'b1;
    lit(21, 4'b1111, 1'b0, 1'b1);
    lit(22, 4'b0000, 1'b1, 1'b0);
    lit(23, 4'b0000, 1'b1, 1'b0);
    bus.cfg_delay = 8'd5;
    lit(24, 4'b0000, 1'b1, 1'b0);
    bus.req_async = 1'b0;
    lit(27, 4'b0000, 1'b1, 1'b0);
    lit(33, 4'b0000, 1'b1, 1'b0);
    lit(34, 4'b0001, 1'b1, 1'b0);
    lit(40, 4'b0011, 1'b1, 1'b0);
    lit(46, 4'b0111, 1'b1, 1'b0);
    lit(51, 4'b0111, 1'b1, 1'b0);
    lit(52, 4'b1111, 1'b0, 1'b1);

    // Abort with 0011 released; release landing as the request arrives still happens.
    do_reset(8'd2, 1'b0);
    lit(10, 4'b0011, 1'b1, 1'b0);
    bus.req_async = 1'b1;
    lit(11, 4'b0011, 1'b1, 1'b0);
    bus.req_async = 1'b0;
    lit(13, 4'b0111, 1'b1, 1'b0);
    lit(14, 4'b0000, 1'b1, 1'b0);
    lit(17, 4'b0000, 1'b1, 1'b0);
    lit(18, 4'b0001, 1'b1, 1'b0);
    lit(21, 4'b0011, 1'b1, 1'b0);
    lit(22, 4'b0011, 1'b1, 1'b0);

    // Asynchronous reset between edges, then the full sequence again.
    #2;
    reset_n = 1'b0;
    #1;
    imm("async_rst", 4'b0000, 1'b1, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    lit(6,  4'b0000, 1'b1, 1'b0);
    lit(7,  4'b0001, 1'b1, 1'b0);
    lit(10, 4'b0011, 1'b1, 1'b0);
    lit(13, 4'b0111, 1'b1, 1'b0);
    lit(16, 4'b1111, 1'b0, 1'b1);

    // Zero gap: one domain per edge.
    do_reset(8'd0, 1'b0);
    lit(4, 4'b0000, 1'b1, 1'b0);
    lit(5, 4'b0001, 1'b1, 1'b0);
    lit(6, 4'b0011, 1'b1, 1'b0);
    lit(7, 4'b0111, 1'b1, 1'b0);
    lit(8, 4'b1111, 1'b0, 1'b1);

    // Test-mode bypass while held in HOLD by the request.
    do_reset(8'd2, 1'b1);
    lit(6, 4'b0000, 1'b1, 1'b0);
    bus.test_mode    = 1'b1;
    bus.test_reset_n = 1'b0;
    #1 imm("tm_lo", 4'b0000, 1'b1, 1'b0);
    bus.test_reset_n = 1'b1;
    #1 imm("tm_hi", 4'b1111, 1'b1, 1'b0);
    bus.test_reset_n = 1'b0;
    #1 imm("tm_lo2", 4'b0000, 1'b1, 1'b0);
    bus.test_reset_n = 1'b1;
    #1;
    bus.test_mode = 1'b0;
    #1 imm("tm_off", 4'b0000, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #2;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      if (bus.req_async) begin
        if ($urandom_range(0, 9) == 0) bus.req_async = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        bus.req_async = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) bus.test_mode = ~bus.test_mode;
      bus.test_reset_n = 1'($urandom_range(0, 1));
      // Gap only changes while not sequencing (quasi-static input).
      if (!seq_on && $urandom_range(0, 3) == 0) bus.cfg_delay = DW'($urandom_range(0, 3));
    end

    @(posedge clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
